seq_run_detector: RTL

SEQ_RUN_DETECTOR -- requirements
Module: seq_run_detector

---
 rtl/seq_run_detector_if.sv | 22 ++
 rtl/seq_run_detector.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seq_run_detector_if.sv
// Sample/detection bus between a sample source and seq_run_detector.
interface seq_run_detector_if #(
    parameter int unsigned DW = 4
);
    logic          in_valid;
    logic [1:0]    mode;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic [DW-1:0] data_out;
    logic [3:0]    run_cnt;
    logic [7:0]    hit_cnt;

    modport master (
        output in_valid, mode, data_in,
        input  out_valid, data_out, run_cnt, hit_cnt
    );

    modport slave (
        input  in_valid, mode, data_in,
        output out_valid, data_out, run_cnt, hit_cnt
    );
endinterface

// File: rtl/seq_run_detector.sv
// Detects runs of RUN_LEN ascending/descending/equal samples on a valid-qualified stream.
// Build option: define SEQ_WRAP_EN for modulo-2^DW progression; otherwise carry/borrow breaks a run.
module seq_run_detector #(
    parameter int unsigned DW      = 4,
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned STEP    = 1
) (
    input logic               sysclk,
    input logic               rst,
    seq_run_detector_if.slave bus
);
    localparam int unsigned AW = DW + 1;

    typedef enum logic [1:0] {IDLE, PRIME, COUNT} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] ref_smp, ref_nxt;
    logic [3:0]    run_q, run_nxt;
    logic          ov_q, ov_nxt;
    logic [DW-1:0] dout_q, dout_nxt;
    logic [7:0]    hit_q, hit_nxt;
    logic [1:0]    mode_q;

    logic [AW-1:0] inc_sum, dec_sum;
    logic          inc_ok, dec_ok, match, run_last, mode_chg;

    assign inc_sum = {1'b0, ref_smp} + AW'(STEP);
    assign dec_sum = {1'b0, ref_smp} - AW'(STEP);

    // A set top bit marks carry/borrow; accepted only when wrapping is enabled.
`ifdef SEQ_WRAP_EN
    assign inc_ok = ({1'b0, bus.data_in} == inc_sum) || ({1'b1, bus.data_in} == inc_sum);
    assign dec_ok = ({1'b0, bus.data_in} == dec_sum) || ({1'b1, bus.data_in} == dec_sum);
`else
    assign inc_ok = ({1'b0, bus.data_in} == inc_sum);
    assign dec_ok = ({1'b0, bus.data_in} == dec_sum);
`endif

    always_comb begin
        match = 1'b0;
        case (bus.mode)
            2'd0:    match = inc_ok;
            2'd1:    match = dec_ok;
            2'd2:    match = (bus.data_in == ref_smp);
            default: match = 1'b0;
        endcase
    end

    assign run_last = (({1'b0, run_q} + 5'd1) == 5'(RUN_LEN));
    assign mode_chg = (bus.mode != mode_q);

    always_comb begin
        state_nxt = state;
        ref_nxt   = ref_smp;
        run_nxt   = run_q;
        ov_nxt    = 1'b0;
        dout_nxt  = '0;
        hit_nxt   = hit_q;
        case (state)
            IDLE: begin
                if (bus.mode != 2'd3) state_nxt = PRIME;
            end
            PRIME: begin
                if (mode_chg || bus.mode == 2'd3) begin
                    run_nxt   = 4'd0;
                    state_nxt = (bus.mode == 2'd3) ? IDLE : PRIME;
                end else if (bus.in_valid) begin
                    ref_nxt   = bus.data_in;
                    run_nxt   = 4'd1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (mode_chg || bus.mode == 2'd3) begin
                    run_nxt   = 4'd0;
                    state_nxt = (bus.mode == 2'd3) ? IDLE : PRIME;
                end else if (!bus.in_valid) begin
                    run_nxt   = 4'd0;
                    state_nxt = PRIME;
                end else begin
                    // Every accepted sample becomes the next reference, hit or miss.
                    ref_nxt = bus.data_in;
                    if (match && run_last) begin
                        ov_nxt   = 1'b1;
                        dout_nxt = bus.data_in;
                        run_nxt  = 4'd1;
                        hit_nxt  = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
                    end else if (match) begin
                        run_nxt = run_q + 4'd1;
                    end else begin
                        run_nxt = 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ref_smp <= '0;
            run_q   <= 4'd0;
            ov_q    <= 1'b0;
            dout_q  <= '0;
            hit_q   <= 8'd0;
            mode_q  <= 2'd3;
        end else begin
            state   <= state_nxt;
            ref_smp <= ref_nxt;
            run_q   <= run_nxt;
            ov_q    <= ov_nxt;
            dout_q  <= dout_nxt;
            hit_q   <= hit_nxt;
            mode_q  <= bus.mode;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.data_out  = dout_q;
    assign bus.run_cnt   = run_q;
    assign bus.hit_cnt   = hit_q;
endmodule
